// File: rtl/tmds_deserializer.sv
// TMDS symbol aligner: DDR bit pairs in, aligned 10-bit words out.
// Bit-slips until control tokens repeat, then holds lock until they vanish.
module tmds_deserializer #(
    parameter int SLIP_WAIT = 4096,
    parameter int LOCK_CNT  = 8,
    parameter int LOST_WAIT = 65535
) (
    input  logic       ser_clk,
    input  logic       rst_n,
    input  logic       rx_en,
    input  logic       din_even,
    input  logic       din_odd,
    output logic [9:0] word,
    output logic       word_valid,
    output logic       is_ctrl,
    output logic [1:0] ctrl,
    output logic       locked,
    output logic [3:0] slip_pos
);
    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    localparam logic [31:0] SW = 32'(SLIP_WAIT);
    localparam logic [31:0] LC = 32'(LOCK_CNT);
    localparam logic [31:0] LW = 32'(LOST_WAIT);

    state_t      state;
    logic [10:0] sr;
    logic [2:0]  phase;
    logic        ext;
    logic [31:0] miss_cnt;
    logic [31:0] tok_cnt;
    logic [31:0] miss_inc;
    logic [31:0] tok_inc;
    logic [9:0]  cand;
    logic        cand_tok;
    logic [1:0]  cand_ctrl;
    logic        slip_req;
    logic        slip_hold;
    logic [3:0]  slip_nxt;

    // Odd offsets end the word on the even bit of the newest pair.
    always_comb begin
        cand      = slip_pos[0] ? sr[9:0] : sr[10:1];
        cand_tok  = 1'b1;
        cand_ctrl = 2'd0;
        unique case (1'b1)
            (cand == 10'b1101010100): cand_ctrl = 2'd0;
            (cand == 10'b0010101011): cand_ctrl = 2'd1;
            (cand == 10'b0101010100): cand_ctrl = 2'd2;
            (cand == 10'b1010101011): cand_ctrl = 2'd3;
            default:                  cand_tok  = 1'b0;
        endcase
    end

    assign miss_inc  = miss_cnt + 32'd1;
    assign tok_inc   = tok_cnt + 32'd1;
    assign slip_nxt  = (slip_pos == 4'd9) ? 4'd0 : slip_pos + 4'd1;
    assign slip_hold = slip_req && !slip_pos[0];

    always_comb begin
        slip_req = 1'b0;
        if (ext && !cand_tok) begin
            case (state)
                SEARCH:  slip_req = (miss_inc >= SW);
                VERIFY:  slip_req = 1'b1;
                default: slip_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge ser_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SEARCH;
            sr         <= '0;
            phase      <= '0;
            ext        <= 1'b0;
            miss_cnt   <= '0;
            tok_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            is_ctrl    <= 1'b0;
            ctrl       <= '0;
            locked     <= 1'b0;
            slip_pos   <= '0;
        end else if (!rx_en) begin
            state      <= SEARCH;
            sr         <= '0;
            phase      <= '0;
            ext        <= 1'b0;
            miss_cnt   <= '0;
            tok_cnt    <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            is_ctrl    <= 1'b0;
            ctrl       <= '0;
            locked     <= 1'b0;
            slip_pos   <= '0;
        end else begin
            sr         <= {din_odd, din_even, sr[10:2]};
            ext        <= (phase == 3'd4);
            word_valid <= ext;
            // An even-to-odd slip pushes the boundary into the next pair.
            if (phase == 3'd4) begin
                phase <= 3'd0;
            end else if (!slip_hold) begin
                phase <= phase + 3'd1;
            end
            if (slip_req) begin
                slip_pos <= slip_nxt;
            end
            if (ext) begin
                word    <= cand;
                is_ctrl <= cand_tok;
                ctrl    <= cand_ctrl;
                case (state)
                    SEARCH: begin
                        if (cand_tok) begin
                            miss_cnt <= '0;
                            if (LC <= 32'd1) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                state   <= VERIFY;
                                tok_cnt <= 32'd1;
                            end
                        end else begin
                            miss_cnt <= slip_req ? '0 : miss_inc;
                        end
                    end
                    VERIFY: begin
                        if (cand_tok) begin
                            if (tok_inc >= LC) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                tok_cnt  <= '0;
                                miss_cnt <= '0;
                            end else begin
                                tok_cnt <= tok_inc;
                            end
                        end else begin
                            state    <= SEARCH;
                            tok_cnt  <= '0;
                            miss_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        if (cand_tok) begin
                            miss_cnt <= '0;
                        end else if (miss_inc >= LW) begin
                            state    <= SEARCH;
                            locked   <= 1'b0;
                            miss_cnt <= '0;
                        end else begin
                            miss_cnt <= miss_inc;
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tmds_deserializer.sv
// Bench for tmds_deserializer: stream-index reference model,
// token table, and hand-placed lock/loss/slip checkpoints.
module tb_tmds_deserializer;
    localparam int MAXC = 4096;
    localparam logic [9:0] T0 = 10'b1101010100;

    logic ser_clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en = 1'b0;
    logic din_even = 1'b0;
    logic din_odd = 1'b0;

    logic [9:0] a_word, b_word;
    logic a_word_valid, b_word_valid;
    logic a_is_ctrl, b_is_ctrl;
    logic [1:0] a_ctrl, b_ctrl;
    logic a_locked, b_locked;
    logic [3:0] a_slip_pos, b_slip_pos;

    always #5 ser_clk = ~ser_clk;

    tmds_deserializer #(
        .SLIP_WAIT(4), .LOCK_CNT(8), .LOST_WAIT(16)
    ) dut_a (
        .ser_clk(ser_clk), .rst_n(rst_n), .rx_en(rx_en),
        .din_even(din_even), .din_odd(din_odd),
        .word(a_word), .word_valid(a_word_valid),
        .is_ctrl(a_is_ctrl), .ctrl(a_ctrl),
        .locked(a_locked), .slip_pos(a_slip_pos)
    );

    tmds_deserializer #(
        .SLIP_WAIT(1), .LOCK_CNT(2), .LOST_WAIT(1)
    ) dut_b (
        .ser_clk(ser_clk), .rst_n(rst_n), .rx_en(rx_en),
        .din_even(din_even), .din_odd(din_odd),
        .word(b_word), .word_valid(b_word_valid),
        .is_ctrl(b_is_ctrl), .ctrl(b_ctrl),
        .locked(b_locked), .slip_pos(b_slip_pos)
    );

    bit q_en[$], q_ev[$], q_od[$], q_rst[$], bq[$];

    bit         ex_v [2][MAXC];
    bit         ex_cw[2][MAXC];
    bit         ex_ic[2][MAXC];
    bit         ex_lk[2][MAXC];
    logic [9:0] ex_w [2][MAXC];
    logic [1:0] ex_ct[2][MAXC];
    logic [3:0] ex_sp[2][MAXC];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        logic [9:0] w;
        bit         ic;
        logic [1:0] ct;
    } vec_t;
    vec_t vecs[6];
    int   vec_cyc[6];

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) begin
            q_en.push_back(1'b0);
            q_ev.push_back(1'b0);
            q_od.push_back(1'b0);
            q_rst.push_back(r);
        end
    endtask

    task automatic add_word(input logic [9:0] w);
        for (int i = 0; i < 10; i++) bq.push_back(w[i]);
    endtask

    task automatic flush();
        while (bq.size() >= 2) begin
            q_en.push_back(1'b1);
            q_ev.push_back(bq.pop_front());
            q_od.push_back(bq.pop_front());
            q_rst.push_back(1'b0);
        end
        bq.delete();
    endtask

    function automatic void decode(input logic [9:0] w,
                                   output bit t, output logic [1:0] c);
        t = 1'b1;
        c = 2'd0;
        case (w)
            10'b1101010100: c = 2'd0;
            10'b0010101011: c = 2'd1;
            10'b0101010100: c = 2'd2;
            10'b1010101011: c = 2'd3;
            default:        t = 1'b0;
        endcase
    endfunction

    // Words are cut straight out of the bit stream by index; a slip
    // just moves the next word start one bit further.
    task automatic run_model(input int d, input int sw,
                             input int lc, input int lw);
        int st, cnt, miss, slip, s, seg, n;
        bit inseg, lk, hic, wt, dos;
        logic [9:0] hw, w;
        logic [1:0] hct, wc;
        n = q_en.size();
        inseg = 0; st = 0; cnt = 0; miss = 0; slip = 0; s = 0; seg = 0;
        lk = 0; hw = '0; hic = 0; hct = '0;
        for (int c = 0; c < n; c++) begin
            ex_v[d][c] = 0;
            ex_cw[d][c] = 0;
            if (q_rst[c] || !q_en[c]) begin
                inseg = 0; st = 0; cnt = 0; miss = 0; slip = 0;
                lk = 0; hw = '0; hic = 0; hct = '0;
                ex_cw[d][c] = 1;
            end else begin
                if (!inseg) begin
                    inseg = 1; seg = c; s = 0;
                end
                if (c == seg + (s + 9) / 2 + 1) begin
                    for (int b = 0; b < 10; b++) begin
                        int k = s + b;
                        w[b] = (k % 2 == 0) ? q_ev[seg + k / 2]
                                            : q_od[seg + k / 2];
                    end
                    decode(w, wt, wc);
                    dos = 0;
                    if (wt) begin
                        if (st == 0) begin
                            miss = 0;
                            if (lc <= 1) st = 2;
                            else begin st = 1; cnt = 1; end
                        end else if (st == 1) begin
                            cnt++;
                            if (cnt >= lc) begin st = 2; cnt = 0; miss = 0; end
                        end else miss = 0;
                    end else begin
                        if (st == 0) begin
                            miss++;
                            if (miss >= sw) begin dos = 1; miss = 0; end
                        end else if (st == 1) begin
                            st = 0; dos = 1; cnt = 0; miss = 0;
                        end else begin
                            miss++;
                            if (miss >= lw) begin st = 0; miss = 0; end
                        end
                    end
                    lk = (st == 2);
                    s += 10;
                    if (dos) begin
                        s += 1;
                        slip = (slip + 1) % 10;
                    end
                    hw = w; hic = wt; hct = wc;
                    ex_v[d][c] = 1;
                    ex_cw[d][c] = 1;
                end
            end
            ex_w[d][c] = hw;
            ex_ic[d][c] = hic;
            ex_ct[d][c] = hct;
            ex_lk[d][c] = lk;
            ex_sp[d][c] = 4'(slip);
        end
    endtask

    task automatic chk(input string nm, input int c,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cycle %0d: got %0h expected %0h",
                         nm, c, act, exp);
        end
    endtask

    task automatic chk_dut(input int d, input int c, input logic v,
                           input logic [9:0] w, input logic ic,
                           input logic [1:0] ct, input logic lk,
                           input logic [3:0] sp);
        string p;
        p = (d == 0) ? "a." : "b.";
        chk({p, "valid"}, c, v, ex_v[d][c]);
        chk({p, "locked"}, c, lk, ex_lk[d][c]);
        chk({p, "slip_pos"}, c, sp, ex_sp[d][c]);
        if (ex_cw[d][c]) begin
            chk({p, "word"}, c, w, ex_w[d][c]);
            chk({p, "is_ctrl"}, c, ic, ex_ic[d][c]);
            chk({p, "ctrl"}, c, ct, ex_ct[d][c]);
        end
    endtask

    initial begin
        int n, seg, cp33, cp35, cp36, cp34, last_b, prev_b;
        bit saw_wrap, clr;

        vecs[0] = '{10'b1101010100, 1'b1, 2'd0};
        vecs[1] = '{10'b0010101011, 1'b1, 2'd1};
        vecs[2] = '{10'b0101010100, 1'b1, 2'd2};
        vecs[3] = '{10'b1010101011, 1'b1, 2'd3};
        vecs[4] = '{10'h155,        1'b0, 2'd0};
        vecs[5] = '{10'h0F0,        1'b0, 2'd0};

        idle(3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            idle(1, 1'b0);
            vec_cyc[i] = q_en.size() + 5;
            add_word(vecs[i].w);
            add_word(10'h000);
            flush();
        end

        idle(2, 1'b0);
        seg = q_en.size();
        for (int i = 0; i < 12; i++) add_word(T0);
        for (int i = 0; i < 18; i++) add_word(10'h155);
        flush();
        cp33 = seg + 40;
        cp35 = seg + 140;

        idle(2, 1'b0);
        bq.push_back(1'b1);
        bq.push_back(1'b0);
        bq.push_back(1'b1);
        for (int i = 0; i < 60; i++) add_word(T0);
        flush();
        cp34 = q_en.size() - 1;

        idle(2, 1'b0);
        seg = q_en.size();
        for (int i = 0; i < 5; i++) add_word(T0);
        add_word(10'h0F0);
        for (int i = 0; i < 8; i++) add_word(10'($urandom()));
        flush();
        cp36 = seg + 30;

        idle(1, 1'b0);
        for (int i = 0; i < 1400; i++) bq.push_back($urandom() % 2 == 1);
        flush();
        q_rst[q_rst.size() - 300] = 1'b1;
        idle(2, 1'b0);

        n = q_en.size();
        run_model(0, 4, 8, 16);
        run_model(1, 1, 2, 1);

        last_b = -1;
        prev_b = 0;
        saw_wrap = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge ser_clk);
            rx_en = q_en[c];
            din_even = q_ev[c];
            din_odd = q_od[c];
            rst_n = !q_rst[c];
            @(posedge ser_clk);
            #1;
            chk_dut(0, c, a_word_valid, a_word, a_is_ctrl, a_ctrl,
                    a_locked, a_slip_pos);
            chk_dut(1, c, b_word_valid, b_word, b_is_ctrl, b_ctrl,
                    b_locked, b_slip_pos);
            for (int i = 0; i < 6; i++) begin
                if (c == vec_cyc[i]) begin
                    chk("tbl.valid", c, a_word_valid, 1);
                    chk("tbl.word", c, a_word, vecs[i].w);
                    chk("tbl.is_ctrl", c, a_is_ctrl, vecs[i].ic);
                    chk("tbl.ctrl", c, a_ctrl, vecs[i].ct);
                end
            end
            if (c == cp33 - 1) chk("lock.pre", c, a_locked, 0);
            if (c == cp33) chk("lock.8th", c, a_locked, 1);
            if (c == cp35 - 1) chk("lost.pre", c, a_locked, 1);
            if (c == cp35) begin
                chk("lost.16th", c, a_locked, 0);
                chk("lost.slip", c, a_slip_pos, 0);
            end
            if (c == cp34) begin
                chk("off3.locked", c, a_locked, 1);
                chk("off3.slip", c, a_slip_pos, 3);
            end
            if (c == cp36) begin
                chk("verify.word", c, a_word, 10'h0F0);
                chk("verify.locked", c, a_locked, 0);
                chk("verify.slip", c, a_slip_pos, 1);
            end
            clr = q_rst[c] || !q_en[c];
            if (clr) begin
                last_b = -1;
            end else if (b_word_valid) begin
                if (last_b >= 0)
                    chk("b.gap", c, ((c - last_b) == 5 || (c - last_b) == 6), 1);
                last_b = c;
            end
            if (!clr && prev_b == 9 && b_slip_pos == 4'd0) saw_wrap = 1;
            prev_b = int'(b_slip_pos);
        end
        chk("b.wrap", n, saw_wrap, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
